// File: rtl/wb_queue.sv
// Write-back queue: buffers ALU/LSU register writes, drains one per cycle into the
// register file and forwards pending values onto the two operand read paths.
module wb_queue #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);
    localparam logic [CW-1:0] CntLast = CW'(DEPTH - 1);

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          alu_push, lsu_push, pop;
    logic [PW-1:0] lsu_slot;

    // Readiness looks only at the registered count; a same-cycle pop never frees a slot.
    always_comb begin
        alu_ready = count_q < CntFull;
        lsu_ready = alu_valid ? (count_q < CntLast) : (count_q < CntFull);
    end

    // Writes to x0 complete the handshake but never occupy a slot.
    always_comb begin
        alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
        lsu_push = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
        pop      = count_q != '0;
        lsu_slot = tail_q + PW'(alu_push);
    end

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(alu_push) + PW'(lsu_push);
        count_d = count_q + CW'(alu_push) + CW'(lsu_push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ALU takes the older slot when both producers push together.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            mem_rd[tail_q]   <= alu_rd;
            mem_data[tail_q] <= alu_data;
        end
        if (lsu_push) begin
            mem_rd[lsu_slot]   <= lsu_rd;
            mem_data[lsu_slot] <= lsu_data;
        end
    end

    always_comb begin
        rf_we = pop && !reset;
        rf_rd = pop ? mem_rd[head_q] : 5'd0;
        rf_wd = pop ? mem_data[head_q] : '0;
        count = count_q;
        full  = count_q == CntFull;
        empty = count_q == '0;
    end

    // Scan oldest to youngest so the last hit is the newest pending value.
    always_comb begin
        op1 = rf_rd1;
        op2 = rf_rd2;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (rs1 != 5'd0 && mem_rd[head_q + PW'(i)] == rs1) begin
                    op1 = mem_data[head_q + PW'(i)];
                end
                if (rs2 != 5'd0 && mem_rd[head_q + PW'(i)] == rs2) begin
                    op2 = mem_data[head_q + PW'(i)];
                end
            end
        end
    end

endmodule
